uart_rx_frontend: RTL and testbench

Serial-to-byte receiver that sits directly upstream of the UART memory-access controller. It oversamples the asynchronous `rx` pin, frames 8N1 characters, and presents each received byte on `RX_data` with a one-cycle `byte_done` strobe. `RX_data` is held stable between bytes, because the downstream controller decodes command bytes from the held level while idle.

---
 rtl/uart_rx_frontend.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_frontend                                              |
// | Purpose  : Oversampling UART receiver. Frames 8N1 characters (8E1/8O1    |
// |            when UART_RX_PARITY_EN is defined), holds the last good byte  |
// |            on RX_data and strobes byte_done / frame_err / parity_err.    |
// | Options  : `define UART_RX_PARITY_EN adds a parity bit before the stop   |
// |            bit; PARITY_ODD selects its sense (0 = even, 1 = odd).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] RX_data,
   output logic       byte_done,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

   // Bit-counter operations requested by the FSM
   localparam logic [1:0] c_CNT_INC = 2'd0;
   localparam logic [1:0] c_CNT_CLR = 2'd1;
   localparam logic [1:0] c_CNT_ONE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   logic               r_sync1;
   logic               r_rx_s;
   state_t             r_state;
   state_t             w_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_idx;
   logic [7:0]         r_shift;
   logic [1:0]         w_cnt_op;
   logic               w_shift;
   logic               w_done;
   logic               w_ferr;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bad;
   logic               w_par_smp;
   logic               w_perr;
`endif

   // Two-flop synchronizer; both stages reset to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM next-state and per-cycle control strobes
   always_comb begin
      w_next   = r_state;
      w_cnt_op = c_CNT_INC;
      w_shift  = 1'b0;
      w_done   = 1'b0;
      w_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp = 1'b0;
      w_perr    = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_op = c_CNT_CLR;
            if (!r_rx_s) begin
               // The detection cycle itself is count 0, so START begins at 1
               // and its mid-bit sample lands (CLKS_PER_BIT-1)/2 after it.
               w_next   = S_START;
               w_cnt_op = c_CNT_ONE;
            end
         end
         S_START: begin
            if (r_cnt == c_HALF) begin
               w_cnt_op = c_CNT_CLR;
               w_next   = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == c_LAST) begin
               w_cnt_op = c_CNT_CLR;
               w_shift  = 1'b1;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_next = S_PARITY;
`else
                  w_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == c_LAST) begin
               w_cnt_op  = c_CNT_CLR;
               w_par_smp = 1'b1;
               w_next    = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == c_LAST) begin
               w_cnt_op = c_CNT_CLR;
               if (r_rx_s) begin
                  w_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (r_par_bad) w_perr = 1'b1;
                  else           w_done = 1'b1;
`else
                  w_done = 1'b1;
`endif
               end else begin
                  // Framing error wins over parity; wait out a possible break
                  w_ferr = 1'b1;
                  w_next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_cnt_op = c_CNT_CLR;
            if (r_rx_s) w_next = S_IDLE;
         end
         default: begin
            w_cnt_op = c_CNT_CLR;
            w_next   = S_IDLE;
         end
      endcase
   end

   // Bit-timing counter, data bit index and LSB-first shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         case (w_cnt_op)
            c_CNT_CLR: r_cnt <= '0;
            c_CNT_ONE: r_cnt <= c_CNT_W'(1);
            default:   r_cnt <= r_cnt + 1'b1;
         endcase
         if (w_shift) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
         end
      end
   end

   // Registered outputs; RX_data only moves together with byte_done
   always_ff @(posedge clk) begin
      if (rst) begin
         RX_data   <= 8'h00;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_done <= w_done;
         frame_err <= w_ferr;
         if (w_done) RX_data <= r_shift;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity verdict over the 8 data bits plus the received parity bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_par_bad  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (w_par_smp) r_par_bad <= (^r_shift) ^ r_rx_s ^ PARITY_ODD;
         parity_err <= w_perr;
      end
   end
`else
   // No parity bit on the wire: the error output never fires and the
   // parity sense has no effect.
   assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_frontend                                           |
// | Purpose  : Directed self-checking bench for uart_rx_frontend. A frame-   |
// |            level model predicts the cycle and kind of each output pulse; |
// |            a compare process checks every output on every cycle.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_frontend;

   localparam int CPB     = 16;
   localparam int HALF    = (CPB - 1) / 2;
   localparam bit PAR_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS   = 11;
   localparam int LAT_LIT = 170;   // 2 sync + 7 + 10*16 + 1
   localparam int GAP_LIT = 176;
`else
   localparam int NBITS   = 10;
   localparam int LAT_LIT = 154;   // 2 sync + 7 + 9*16 + 1
   localparam int GAP_LIT = 160;
`endif

   localparam int K_DONE = 0;
   localparam int K_FERR = 1;
   localparam int K_PERR = 2;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] RX_data;
   logic       byte_done;
   logic       frame_err;
   logic       parity_err;

   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   int         n_done = 0;
   int         n_ferr = 0;
   int         n_perr = 0;
   int         done_cyc[$];
   logic [7:0] done_dat[$];
   ev_t        q[$];
   logic [7:0] m_data = 8'h00;
   bit         armed  = 1'b0;

   uart_rx_frontend #(
      .CLKS_PER_BIT (CPB),
      .PARITY_ODD   (PAR_ODD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .RX_data    (RX_data),
      .byte_done  (byte_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Send one character starting in the current cycle. The model entry is
   // derived from frame arithmetic: the verdict is known 2 sync cycles +
   // half a bit + (NBITS-1) whole bits after the start edge, and shows one
   // cycle later. abort_bit >= 0 pulses rst halfway through that data bit.
   task automatic send(input logic [7:0] d, input bit stop, input bit pflip,
                       input int abort_bit);
      ev_t e;
      e.cyc  = cyc + 2 + HALF + (NBITS - 1) * CPB + 1;
      e.data = d;
      if (!stop)      e.kind = K_FERR;
      else if (pflip) e.kind = K_PERR;
      else            e.kind = K_DONE;
      q.push_back(e);
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (i == abort_bit) begin
            step(CPB / 2);
            rst = 1'b1;
            rx  = 1'b1;
            step(1);
            rst = 1'b0;
            return;
         end
         step(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ PAR_ODD ^ pflip;
      step(CPB);
`endif
      rx = stop;
      step(CPB);
   endtask

   // Per-cycle comparison against the frame model, plus pulse bookkeeping
   always @(negedge clk) begin
      bit e_done, e_ferr, e_perr;
      e_done = 1'b0;
      e_ferr = 1'b0;
      e_perr = 1'b0;
      if (armed) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            case (q[0].kind)
               K_DONE: begin e_done = 1'b1; m_data = q[0].data; end
               K_FERR: e_ferr = 1'b1;
               default: e_perr = 1'b1;
            endcase
            void'(q.pop_front());
         end
         chk("byte_done", {31'd0, byte_done}, {31'd0, e_done});
         chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
         chk("parity_err", {31'd0, parity_err}, {31'd0, e_perr});
         chk("RX_data", {24'd0, RX_data}, {24'd0, m_data});
         if (byte_done === 1'b1) begin
            n_done++;
            done_cyc.push_back(cyc);
            done_dat.push_back(RX_data);
         end
         if (frame_err === 1'b1) n_ferr++;
         if (parity_err === 1'b1) n_perr++;
      end
      if (rst) begin
         q.delete();
         m_data = 8'h00;
         armed  = 1'b1;
      end
   end

   initial begin
      int n0, b, f;
      step(3);
      rst = 1'b0;
      chk("reset RX_data", {24'd0, RX_data}, 32'h0);
      chk("reset byte_done", {31'd0, byte_done}, 32'h0);
      chk("reset frame_err", {31'd0, frame_err}, 32'h0);
      chk("reset parity_err", {31'd0, parity_err}, 32'h0);
      step(10);

      // Single byte, then a long idle hold
      n0 = cyc;
      send(8'h0F, 1'b1, 1'b0, -1);
      step(500);
      chk("single count", n_done, 1);
      chk("single latency", done_cyc[0] - n0, LAT_LIT);
      chk("single data", {24'd0, RX_data}, 32'h0F);

      // Back-to-back characters with one stop bit
      b = n_done;
      send(8'hFF, 1'b1, 1'b0, -1);
      send(8'h34, 1'b1, 1'b0, -1);
      send(8'h12, 1'b1, 1'b0, -1);
      step(50);
      chk("b2b count", n_done - b, 3);
      if (n_done - b == 3) begin
         chk("b2b gap1", done_cyc[b + 1] - done_cyc[b], GAP_LIT);
         chk("b2b gap2", done_cyc[b + 2] - done_cyc[b + 1], GAP_LIT);
         chk("b2b d0", {24'd0, done_dat[b]}, 32'hFF);
         chk("b2b d1", {24'd0, done_dat[b + 1]}, 32'h34);
         chk("b2b d2", {24'd0, done_dat[b + 2]}, 32'h12);
      end

      // Start-bit glitch shorter than half a bit
      b = n_done;
      f = n_ferr;
      rx = 1'b0;
      step(5);
      rx = 1'b1;
      step(100);
      chk("glitch no byte", n_done - b, 0);
      chk("glitch no ferr", n_ferr - f, 0);
      send(8'hA5, 1'b1, 1'b0, -1);
      step(20);
      chk("after glitch data", {24'd0, RX_data}, 32'hA5);

      // Framing error followed by a break
      b = n_done;
      f = n_ferr;
      send(8'h55, 1'b0, 1'b0, -1);
      step(10 * CPB);
      chk("break hold data", {24'd0, RX_data}, 32'hA5);
      step(10 * CPB);
      rx = 1'b1;
      step(40);
      chk("ferr count", n_ferr - f, 1);
      chk("break no byte", n_done - b, 0);
      send(8'h3C, 1'b1, 1'b0, -1);
      step(20);
      chk("after break data", {24'd0, RX_data}, 32'h3C);

      // Reset during data bit 4
      b = n_done;
      send(8'h81, 1'b1, 1'b0, 4);
      chk("midrst RX_data", {24'd0, RX_data}, 32'h0);
      chk("midrst byte_done", {31'd0, byte_done}, 32'h0);
      step(200);
      chk("midrst no byte", n_done - b, 0);
      send(8'h7E, 1'b1, 1'b0, -1);
      step(20);
      chk("after rst data", {24'd0, RX_data}, 32'h7E);

`ifdef UART_RX_PARITY_EN
      // Even parity: correct bit then flipped bit
      b = n_done;
      f = n_perr;
      send(8'h03, 1'b1, 1'b0, -1);
      step(20);
      chk("par good data", {24'd0, RX_data}, 32'h03);
      send(8'h03, 1'b1, 1'b1, -1);
      step(20);
      chk("par bad perr", n_perr - f, 1);
      chk("par byte count", n_done - b, 1);
      chk("par hold data", {24'd0, RX_data}, 32'h03);
`endif

      step(20);
      chk("model drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
